// File: rtl/dial_decoder.sv
// Safe-dial puzzle decoder: consumes rotation words one per handshake and counts
// how often the 0..99 dial ends on 0 (part1) and how many clicks land on 0 (part2).
module dial_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [15:0] total_num_turns_i,
    input  logic [15:0] data_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic [15:0] part1_o,
    output logic [31:0] part2_o,
    output logic [6:0]  pos_o,
    output logic        done_o,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_STEP   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t      state;
    logic [15:0] remaining;
    logic [14:0] rem;
    logic        dir;

    // Final-step result: only meaningful once rem < 100, so rem[6:0] holds all of it.
    logic [7:0]  step_sum;
    logic [6:0]  step_pos;
    logic        step_hit;

    always_comb begin
        step_sum = 8'd0;
        step_pos = pos_o;
        step_hit = 1'b0;
        if (!dir) begin
            step_sum = {1'b0, pos_o} + {1'b0, rem[6:0]};
            if (step_sum >= 8'd100) begin
                step_sum = step_sum - 8'd100;
                step_hit = 1'b1;
            end
        end else begin
            if (rem[6:0] <= pos_o)
                step_sum = {1'b0, pos_o} - {1'b0, rem[6:0]};
            else
                step_sum = {1'b0, pos_o} + 8'd100 - {1'b0, rem[6:0]};
            step_hit = (rem[6:0] != 7'd0) && (pos_o != 7'd0) && (rem[6:0] >= pos_o);
        end
        step_pos = step_sum[6:0];
    end

    // Handshake: a rotation is taken on a rising edge where valid_i && ready_o;
    // ready_o is decoded from the registered state only, never from valid_i.
    assign ready_o = (state == S_ACCEPT);
    assign done_o  = (state == S_DONE);
    assign state_o = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            pos_o     <= 7'd50;
            part1_o   <= 16'd0;
            part2_o   <= 32'd0;
            remaining <= 16'd0;
            rem       <= 15'd0;
            dir       <= 1'b0;
        end else if (start_i) begin
            pos_o     <= 7'd50;
            part1_o   <= 16'd0;
            part2_o   <= 32'd0;
            remaining <= total_num_turns_i;
            state     <= (total_num_turns_i != 16'd0) ? S_ACCEPT : S_DONE;
        end else begin
            case (state)
                S_ACCEPT: begin
                    if (valid_i) begin
                        dir   <= data_i[15];
                        rem   <= data_i[14:0];
                        state <= S_STEP;
                    end
                end
                S_STEP: begin
                    // Whole revolutions are retired one per cycle before the final partial move.
                    if (rem >= 15'd100) begin
                        rem     <= rem - 15'd100;
                        part2_o <= part2_o + 32'd1;
                    end else begin
                        pos_o     <= step_pos;
                        rem       <= 15'd0;
                        remaining <= remaining - 16'd1;
                        if (step_hit)
                            part2_o <= part2_o + 32'd1;
                        if (step_pos == 7'd0)
                            part1_o <= part1_o + 16'd1;
                        state <= (remaining == 16'd1) ? S_DONE : S_ACCEPT;
                    end
                end
                default: state <= state;
            endcase
        end
    end

endmodule

// File: tb/tb_dial_decoder.sv
// Directed bench for dial_decoder: worked puzzle example, long and wrapping
// rotations, empty run, start/transfer collision and mid-run reset.
module tb_dial_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic [15:0] total_num_turns_i = 16'd0;
    logic [15:0] data_i = 16'd0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [15:0] part1_o;
    logic [31:0] part2_o;
    logic [6:0]  pos_o;
    logic        done_o;
    logic [1:0]  state_o;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCEPT = 2'd1;
    localparam logic [1:0] ST_STEP   = 2'd2;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] aoc [10] = '{16'h8044, 16'h801E, 16'h0030, 16'h8005, 16'h003C,
                              16'h8037, 16'h8001, 16'h8063, 16'h000E, 16'h8052};

    dial_decoder dut (
        .clk(clk), .rst(rst), .start_i(start_i), .total_num_turns_i(total_num_turns_i),
        .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o), .part1_o(part1_o),
        .part2_o(part2_o), .pos_o(pos_o), .done_o(done_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start_run(input logic [15:0] total);
        @(negedge clk);
        start_i = 1'b1;
        total_num_turns_i = total;
        @(negedge clk);
        start_i = 1'b0;
        total_num_turns_i = 16'hFFFF;
    endtask

    // Leaves us on the falling edge right after the accepting rising edge.
    task automatic send(input logic [15:0] word, input int gap);
        int budget;
        for (int i = 0; i < gap; i++) begin
            valid_i = 1'b0;
            data_i = 16'($urandom);
            @(negedge clk);
        end
        valid_i = 1'b1;
        data_i = word;
        budget = 0;
        while (!ready_o && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        n_cmp++;
        if (ready_o !== 1'b1) begin
            n_bad++;
            $display("FAIL send_ready: word %h ready_o=%b required 1", word, ready_o);
        end
        @(negedge clk);
        valid_i = 1'b0;
        data_i = 16'($urandom);
    endtask

    task automatic wait_done();
        int cyc;
        cyc = 0;
        while (!done_o && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (done_o !== 1'b1) begin
            n_bad++;
            $display("FAIL wait_done: done_o=%b required 1", done_o);
        end
    endtask

    task automatic count_steps(output int n);
        n = 0;
        while (state_o == ST_STEP && n < 2000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic check_results(input string name, input logic [15:0] p1,
                                 input logic [31:0] p2, input logic [6:0] ps);
        n_cmp++;
        if (part1_o !== p1) begin
            n_bad++;
            $display("FAIL %s part1: got %0d required %0d", name, part1_o, p1);
        end
        n_cmp++;
        if (part2_o !== p2) begin
            n_bad++;
            $display("FAIL %s part2: got %0d required %0d", name, part2_o, p2);
        end
        n_cmp++;
        if (pos_o !== ps) begin
            n_bad++;
            $display("FAIL %s pos: got %0d required %0d", name, pos_o, ps);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_results("reset", 16'd0, 32'd0, 7'd50);
        n_cmp++;
        if (ready_o !== 1'b0 || done_o !== 1'b0 || state_o !== ST_IDLE) begin
            n_bad++;
            $display("FAIL reset_ctrl: ready=%b done=%b state=%0d required 0 0 0", ready_o, done_o, state_o);
        end
        rst = 1'b0;
        // Idle must ignore a presented rotation.
        valid_i = 1'b1;
        data_i = 16'h8044;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (state_o !== ST_IDLE || ready_o !== 1'b0 || pos_o !== 7'd50) begin
            n_bad++;
            $display("FAIL idle_ignore: state=%0d ready=%b pos=%0d required 0 0 50", state_o, ready_o, pos_o);
        end
        valid_i = 1'b0;
    endtask

    task automatic test_aoc(input logic gapped);
        start_run(16'd10);
        for (int i = 0; i < 10; i++)
            send(aoc[i], gapped ? int'($urandom_range(0, 3)) : 0);
        wait_done();
        check_results(gapped ? "aoc_gapped" : "aoc", 16'd3, 32'd6, 7'd32);
        // DONE holds its outputs even with valid_i pushed at it.
        valid_i = 1'b1;
        data_i = 16'h0005;
        repeat (4) @(negedge clk);
        valid_i = 1'b0;
        n_cmp++;
        if (done_o !== 1'b1 || ready_o !== 1'b0 || pos_o !== 7'd32 || part2_o !== 32'd6) begin
            n_bad++;
            $display("FAIL done_hold: done=%b ready=%b pos=%0d part2=%0d required 1 0 32 6", done_o, ready_o, pos_o, part2_o);
        end
    endtask

    task automatic test_r1000();
        int n;
        start_run(16'd1);
        send(16'h03E8, 0);
        count_steps(n);
        n_cmp++;
        if (n != 11) begin
            n_bad++;
            $display("FAIL r1000_steps: got %0d required 11", n);
        end
        wait_done();
        check_results("r1000", 16'd0, 32'd10, 7'd50);
    endtask

    task automatic test_back_to_back();
        int n;
        start_run(16'd2);
        send(16'h8032, 0);
        count_steps(n);
        n_cmp++;
        if (n != 1) begin
            n_bad++;
            $display("FAIL l50_steps: got %0d required 1", n);
        end
        n_cmp++;
        if (ready_o !== 1'b1) begin
            n_bad++;
            $display("FAIL l50_ready_after: got %b required 1", ready_o);
        end
        send(16'h8064, 0);
        count_steps(n);
        n_cmp++;
        if (n != 2) begin
            n_bad++;
            $display("FAIL l100_steps: got %0d required 2", n);
        end
        wait_done();
        check_results("l50_l100", 16'd2, 32'd2, 7'd0);
    endtask

    task automatic test_zero_total();
        logic seen_ready;
        start_run(16'd0);
        n_cmp++;
        if (done_o !== 1'b1) begin
            n_bad++;
            $display("FAIL zero_done: got %b required 1", done_o);
        end
        seen_ready = ready_o;
        repeat (5) begin
            @(negedge clk);
            seen_ready = seen_ready | ready_o;
        end
        n_cmp++;
        if (seen_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_ready: got %b required 0", seen_ready);
        end
        check_results("zero", 16'd0, 32'd0, 7'd50);
    endtask

    task automatic test_start_collision();
        start_run(16'd3);
        valid_i = 1'b1;
        data_i = 16'h8044;
        start_i = 1'b1;
        total_num_turns_i = 16'd1;
        @(negedge clk);
        start_i = 1'b0;
        valid_i = 1'b0;
        n_cmp++;
        if (state_o !== ST_ACCEPT) begin
            n_bad++;
            $display("FAIL collide_state: got %0d required %0d", state_o, ST_ACCEPT);
        end
        send(16'h0032, 1);
        wait_done();
        check_results("collide", 16'd1, 32'd1, 7'd0);
    endtask

    task automatic test_rst_mid_step();
        start_run(16'd1);
        send(16'h03E8, 0);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (state_o !== ST_STEP) begin
            n_bad++;
            $display("FAIL rst_pre_state: got %0d required %0d", state_o, ST_STEP);
        end
        #2 rst = 1'b1;
        #1;
        check_results("rst_async", 16'd0, 32'd0, 7'd50);
        n_cmp++;
        if (state_o !== ST_IDLE || ready_o !== 1'b0 || done_o !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_async_ctrl: state=%0d ready=%b done=%b required 0 0 0", state_o, ready_o, done_o);
        end
        @(negedge clk);
        rst = 1'b0;
        start_run(16'd1);
        send(16'h0032, 0);
        wait_done();
        check_results("rst_restart", 16'd1, 32'd1, 7'd0);
    endtask

    initial begin
        test_reset();
        test_aoc(1'b0);
        test_r1000();
        test_back_to_back();
        test_zero_total();
        test_aoc(1'b1);
        test_start_collision();
        test_rst_mid_step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
